// File: rtl/key_event_decoder.sv
// key_event_decoder: turns debounced key levels into PRESS/RELEASE/LONG/REPEAT
// events for one tracked key at a time, queued in a 4-deep FIFO.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   Key_In[4:0]              debounced key levels, 1 = pressed
//   Evt_Ready                consumer pops the head event
//   Evt_Valid                FIFO not empty
//   Evt_Key[2:0]             key index of head event
//   Evt_Type[1:0]            00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
//   Evt_Count[2:0]           events stored (0-4)
//   Overflow                 sticky, an event was dropped on a full FIFO
// Build option: define KEY_EVENT_REPEAT_EN to emit REPEAT events in AUTO.
module key_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] Key_In,
  input  logic       Evt_Ready,
  output logic       Evt_Valid,
  output logic [2:0] Evt_Key,
  output logic [1:0] Evt_Type,
  output logic [2:0] Evt_Count,
  output logic       Overflow
);

  localparam int unsigned MAXC =
    (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_AUTO
  } state_e;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_LONG    = 2'b10,
    EV_REPEAT  = 2'b11
  } evt_e;

  typedef struct packed {
    logic [2:0] key;
    evt_e       typ;
  } evt_t;

  // ---------------------------------------------------------------
  // Key sampling and rising-edge detection
  // ---------------------------------------------------------------
  logic [4:0] key_q;
  logic [4:0] key_prev_q;
  logic       prime_q;
  logic [4:0] rise;
  logic [2:0] rise_idx;

  // The first clock after reset loads both stages with the same
  // value, so keys already held at reset release never look like
  // a fresh press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_q      <= '0;
      key_prev_q <= '0;
      prime_q    <= 1'b1;
    end else begin
      key_q      <= Key_In;
      key_prev_q <= prime_q ? Key_In : key_q;
      prime_q    <= 1'b0;
    end
  end

  assign rise = key_q & ~key_prev_q;

  // Lowest-index rising key wins.
  always_comb begin
    rise_idx = '0;
    for (int i = 4; i >= 0; i--) begin
      if (rise[i]) begin
        rise_idx = 3'(i);
      end
    end
  end

  // ---------------------------------------------------------------
  // Tracking FSM (registered push request to the FIFO)
  // ---------------------------------------------------------------
  state_e        state_q;
  logic [2:0]    trk_q;
  logic [CW-1:0] cnt_q;
  logic          push_q;
  logic [2:0]    pkey_q;
  evt_e          ptype_q;
  logic          held;

  assign held = |(key_q & (5'b00001 << trk_q));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      trk_q   <= '0;
      cnt_q   <= '0;
      push_q  <= 1'b0;
      pkey_q  <= '0;
      ptype_q <= EV_PRESS;
    end else begin
      push_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|rise) begin
            trk_q   <= rise_idx;
            cnt_q   <= '0;
            push_q  <= 1'b1;
            pkey_q  <= rise_idx;
            ptype_q <= EV_PRESS;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Release wins over LONG in the same cycle.
          if (!held) begin
            push_q  <= 1'b1;
            pkey_q  <= trk_q;
            ptype_q <= EV_RELEASE;
            state_q <= S_IDLE;
          end else if (cnt_q == LONG_LAST) begin
            push_q  <= 1'b1;
            pkey_q  <= trk_q;
            ptype_q <= EV_LONG;
            cnt_q   <= '0;
            state_q <= S_AUTO;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_AUTO: begin
          if (!held) begin
            push_q  <= 1'b1;
            pkey_q  <= trk_q;
            ptype_q <= EV_RELEASE;
            state_q <= S_IDLE;
          end
`ifdef KEY_EVENT_REPEAT_EN
          else if (cnt_q == REP_LAST) begin
            push_q  <= 1'b1;
            pkey_q  <= trk_q;
            ptype_q <= EV_REPEAT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // 4-deep event FIFO
  // ---------------------------------------------------------------
  evt_t       mem_q [4];
  logic [1:0] wr_q;
  logic [1:0] rd_q;
  logic [2:0] fcnt_q;
  logic [2:0] fcnt_d;
  logic       ovf_q;
  logic       full;
  logic       pop;
  logic       wr_en;
  logic       drop;
  evt_t       head;

  assign full  = (fcnt_q == 3'd4);
  assign pop   = (fcnt_q != 3'd0) && Evt_Ready;
  // A pop in the same cycle frees the slot, so a full FIFO still
  // accepts the push.
  assign wr_en = push_q && (!full || pop);
  assign drop  = push_q && full && !pop;

  always_comb begin
    fcnt_d = fcnt_q;
    unique case ({wr_en, pop})
      2'b10:   fcnt_d = fcnt_q + 3'd1;
      2'b01:   fcnt_d = fcnt_q - 3'd1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= '{key: pkey_q, typ: ptype_q};
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) begin
        rd_q <= rd_q + 2'd1;
      end
      fcnt_q <= fcnt_d;
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign head      = mem_q[rd_q];
  assign Evt_Valid = (fcnt_q != 3'd0);
  assign Evt_Key   = Evt_Valid ? head.key : 3'd0;
  assign Evt_Type  = Evt_Valid ? head.typ : 2'b00;
  assign Evt_Count = fcnt_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed and random checks of key_event_decoder
// against an event-level reference model.
module tb_key_event_decoder;

  localparam int L = 16;
  localparam int R = 4;

  localparam logic [1:0] PRESS   = 2'b00;
  localparam logic [1:0] RELEASE = 2'b01;
  localparam logic [1:0] LONG    = 2'b10;
  localparam logic [1:0] REPEAT  = 2'b11;

`ifdef KEY_EVENT_REPEAT_EN
  localparam int N_LONG_SEQ = 6;
`else
  localparam int N_LONG_SEQ = 3;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] Key_In = '0;
  logic       Evt_Ready = 1'b1;
  logic       Evt_Valid;
  logic [2:0] Evt_Key;
  logic [1:0] Evt_Type;
  logic [2:0] Evt_Count;
  logic       Overflow;

  key_event_decoder #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Key_In   (Key_In),
    .Evt_Ready(Evt_Ready),
    .Evt_Valid(Evt_Valid),
    .Evt_Key  (Evt_Key),
    .Evt_Type (Evt_Type),
    .Evt_Count(Evt_Count),
    .Overflow (Overflow)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic       rec = 1'b0;
  logic [4:0] samp [$];
  logic [4:0] obs  [$];
  logic [4:0] expq [$];

  // Key_In is driven 1 time unit after posedge, so the level seen
  // here is what the next posedge samples.
  always @(negedge CLK) begin
    if (rec) begin
      samp.push_back(Key_In);
      if (Evt_Valid && Evt_Ready) begin
        obs.push_back({Evt_Key, Evt_Type});
      end
    end
  end

  task automatic check(input string tag, input int got, input int want);
    total++;
    assert (got === want) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Event list from the sampled key history: one key tracked at a
  // time, PRESS on the lowest rising key, LONG once held more than
  // L samples, REPEAT for every further R samples, RELEASE on the
  // first low sample.
  function automatic void build_model();
    int n;
    int r;
    int h;
    int k;
    logic [4:0] rs;
    expq.delete();
    n = 1;
    while (n < samp.size()) begin
      rs = samp[n] & ~samp[n-1];
      if (rs == 5'd0) begin
        n++;
        continue;
      end
      k = 0;
      while (!rs[k]) k++;
      expq.push_back({3'(k), PRESS});
      r = n + 1;
      while (r < samp.size() && samp[r][k]) r++;
      h = r - n;
      if (h >= L + 1) begin
        expq.push_back({3'(k), LONG});
`ifdef KEY_EVENT_REPEAT_EN
        for (int j = 1; h >= L + 1 + R * j; j++) begin
          expq.push_back({3'(k), REPEAT});
        end
`endif
      end
      if (r < samp.size()) begin
        expq.push_back({3'(k), RELEASE});
      end
      n = r + 1;
    end
  endfunction

  task automatic cmp_events(input string tag, input int nexp);
    int want;
    build_model();
    want = (nexp < 0) ? expq.size() : nexp;
    check({tag, " count"}, obs.size(), want);
    for (int i = 0; i < want && i < obs.size() && i < expq.size(); i++) begin
      check($sformatf("%s ev%0d", tag, i), obs[i], expq[i]);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, " valid"}, Evt_Valid, 0);
    check({tag, " key"},   Evt_Key,   0);
    check({tag, " type"},  Evt_Type,  0);
    check({tag, " count"}, Evt_Count, 0);
    check({tag, " ovf"},   Overflow,  0);
  endtask

  // Entered and left at posedge+1.
  task automatic do_reset(input logic [4:0] k);
    rec       = 1'b0;
    RST       = 1'b1;
    Key_In    = k;
    Evt_Ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    samp.delete();
    obs.delete();
    RST = 1'b0;
    rec = 1'b1;
  endtask

  task automatic hold(input logic [4:0] k, input int n);
    Key_In = k;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [4:0] k;

    @(posedge CLK);
    #1;
    chk_zero("reset");

    // Latency and short press
    do_reset(5'd0);
    hold(5'd0, 3);
    Key_In = 5'b00001;
    @(posedge CLK); #1;
    check("lat edge1 valid", Evt_Valid, 0);
    @(posedge CLK); #1;
    check("lat edge2 valid", Evt_Valid, 0);
    @(posedge CLK); #1;
    check("lat edge3 valid", Evt_Valid, 1);
    check("lat edge3 key", Evt_Key, 0);
    check("lat edge3 type", Evt_Type, PRESS);
    hold(5'b00001, 2);
    hold(5'd0, 40);
    rec = 1'b0;
    cmp_events("short", 2);

    // Long hold
    do_reset(5'd0);
    hold(5'd0, 2);
    hold(5'b00100, 30);
    hold(5'd0, 40);
    rec = 1'b0;
    cmp_events("long", N_LONG_SEQ);

    // Simultaneous rise, untracked release
    do_reset(5'd0);
    hold(5'd0, 2);
    hold(5'b10010, 6);
    hold(5'b00010, 6);
    hold(5'd0, 40);
    rec = 1'b0;
    cmp_events("multi", 2);

    // Overflow
    do_reset(5'd0);
    Evt_Ready = 1'b0;
    hold(5'd0, 2);
    repeat (3) begin
      hold(5'b01000, 3);
      hold(5'd0, 3);
    end
    hold(5'd0, 10);
    check("ovf count", Evt_Count, 4);
    check("ovf flag", Overflow, 1);
    Evt_Ready = 1'b1;
    hold(5'd0, 10);
    rec = 1'b0;
    check("ovf drained", Evt_Count, 0);
    cmp_events("ovf", 4);

    // Reset during AUTO with two events queued
    do_reset(5'd0);
    Evt_Ready = 1'b0;
    hold(5'd0, 2);
    hold(5'b00100, 19);
    check("auto queued", Evt_Count, 2);
    RST = 1'b1;
    #1;
    chk_zero("async rst");
    do_reset(5'b00100);
    hold(5'b00100, 30);
    hold(5'd0, 40);
    rec = 1'b0;
    cmp_events("post rst", 0);

    // Random key activity
    k = 5'($urandom_range(31));
    do_reset(k);
    for (int s = 0; s < 800; s++) begin
      if ($urandom_range(9) == 0) begin
        int b;
        b = $urandom_range(4);
        k[b] = ~k[b];
      end
      hold(k, 1);
    end
    hold(5'd0, 40);
    rec = 1'b0;
    cmp_events("rand", -1);
    check("rand ovf", Overflow, 0);
    check("rand count", Evt_Count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
